// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor that resolves BLOCK bits per clock.
// The group carry is registered between cycles. Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
module cla_seq_adder #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NUM_BLK = WIDTH / BLOCK;
    localparam int IDXW    = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BLK - 1);

    if ((BLOCK < 1) || (WIDTH < 2) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
        $error("cla_seq_adder: WIDTH must be >= 2 and a multiple of BLOCK >= 1");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              c_q, c_d, cout_q, cout_d, done_q, done_d;
`ifdef CLA_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    int unsigned       base;
    logic [BLOCK-1:0]  ga, gb, gg, gp, gs;
    logic [BLOCK:0]    gc;
    logic              acc, pp;

    // Per-bit carries are expanded as sums of generate terms gated by propagate runs, not a ripple chain.
    always_comb begin
        base  = 32'(idx_q) * 32'(BLOCK);
        ga    = a_q[base +: BLOCK];
        gb    = b_q[base +: BLOCK];
        gg    = ga & gb;
        gp    = ga ^ gb;
        gc    = '0;
        gc[0] = c_q;
        acc   = 1'b0;
        pp    = 1'b0;
        for (int unsigned k = 0; k < BLOCK; k++) begin
            acc = gg[k];
            pp  = gp[k];
            for (int unsigned j = k; j > 0; j--) begin
                acc = acc | (pp & gg[j-1]);
                pp  = pp & gp[j-1];
            end
            gc[k+1] = acc | (pp & c_q);
        end
        gs = gp ^ gc[BLOCK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        sum  = sum_q;
        cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
        ovf  = ovf_q;
`endif
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        idx_d  = idx_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        done_d = 1'b0;
`ifdef CLA_SEQ_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                a_d    = a;
                b_d    = sub ? ~b : b;
                c_d    = sub ? 1'b1 : cin;
                idx_d  = '0;
                sum_d  = '0;
                cout_d = 1'b0;
`ifdef CLA_SEQ_OVF_EN
                ovf_d  = 1'b0;
`endif
            end
        end else begin
            sum_d[base +: BLOCK] = gs;
            c_d   = gc[BLOCK];
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                cout_d = gc[BLOCK];
                done_d = 1'b1;
`ifdef CLA_SEQ_OVF_EN
                ovf_d  = gc[BLOCK] ^ gc[BLOCK-1];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            idx_q  <= idx_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            done_q <= done_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder at WIDTH=8, BLOCK=2.
// Checks ovf as well when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;
    logic       clk = 1'b0;
    logic       rst_n, start, sub, cin;
    logic [7:0] a, b, sum;
    logic       busy, done, cout;
`ifdef CLA_SEQ_OVF_EN
    logic       ovf;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(8), .BLOCK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tsub, input logic tcin);
        a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Stops on the first cycle done is seen, counting busy cycles before it; bounded.
    task automatic wait_done(output int busy_cyc, output bit seen);
        busy_cyc = 0;
        seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy === 1'b1) busy_cyc++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #2;
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            errors++;
            $display("FAIL reset_hold: busy/done/cout/sum got %b want 00000000000", {busy, done, cout, sum});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            errors++;
            $display("FAIL reset_release: busy/done/cout/sum got %b want 00000000000", {busy, done, cout, sum});
        end
`ifdef CLA_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    endtask

    task automatic test_add();
        logic [7:0] va [2] = '{8'h5A, 8'h7F};
        logic [7:0] vb [2] = '{8'h3C, 8'h00};
        logic       vc [2] = '{1'b0, 1'b1};
        logic [7:0] es [2] = '{8'h96, 8'h80};
        logic       ec [2] = '{1'b0, 1'b0};
`ifdef CLA_SEQ_OVF_EN
        logic       eo [2] = '{1'b1, 1'b1};
`endif
        int bc; bit seen;
        for (int i = 0; i < 2; i++) begin
            launch(va[i], vb[i], 1'b0, vc[i]);
            wait_done(bc, seen);
            checks++;
            if (!seen) begin errors++; $display("FAIL add_done[%0d]: no done within bound", i); end
            checks++;
            if (bc != 4) begin errors++; $display("FAIL add_busy[%0d]: got %0d cycles want 4", i, bc); end
            checks++;
            if (sum !== es[i]) begin errors++; $display("FAIL add_sum[%0d]: got %h want %h", i, sum, es[i]); end
            checks++;
            if (cout !== ec[i]) begin errors++; $display("FAIL add_cout[%0d]: got %b want %b", i, cout, ec[i]); end
`ifdef CLA_SEQ_OVF_EN
            checks++;
            if (ovf !== eo[i]) begin errors++; $display("FAIL add_ovf[%0d]: got %b want %b", i, ovf, eo[i]); end
`endif
            step();
            checks++;
            if (done !== 1'b0 || sum !== es[i]) begin
                errors++;
                $display("FAIL add_pulse_hold[%0d]: done %b sum %h want done 0 sum %h", i, done, sum, es[i]);
            end
        end
    endtask

    task automatic test_ripple();
        int bc; bit seen;
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(bc, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL ripple_done: no done within bound"); end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple: sum %h cout %b want sum 00 cout 1", sum, cout);
        end
`ifdef CLA_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ripple_ovf: got %b want 0", ovf); end
`endif
        step();
    endtask

    task automatic test_sub();
        logic [7:0] va [2] = '{8'h10, 8'h20};
        logic [7:0] vb [2] = '{8'h20, 8'h10};
        logic [7:0] es [2] = '{8'hF0, 8'h10};
        logic       ec [2] = '{1'b0, 1'b1};
        int bc; bit seen;
        for (int i = 0; i < 2; i++) begin
            launch(va[i], vb[i], 1'b1, 1'b1);
            wait_done(bc, seen);
            checks++;
            if (!seen) begin errors++; $display("FAIL sub_done[%0d]: no done within bound", i); end
            checks++;
            if (sum !== es[i]) begin errors++; $display("FAIL sub_sum[%0d]: got %h want %h", i, sum, es[i]); end
            checks++;
            if (cout !== ec[i]) begin errors++; $display("FAIL sub_cout[%0d]: got %b want %b", i, cout, ec[i]); end
`ifdef CLA_SEQ_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf[%0d]: got %b want 0", i, ovf); end
`endif
            step();
        end
        sub = 1'b0; cin = 1'b0;
    endtask

    task automatic test_collision();
        int bc; bit seen; int extra;
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        step();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(bc, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL collide_done: no done within bound"); end
        checks++;
        if (sum !== 8'h02 || cout !== 1'b0) begin
            errors++;
            $display("FAIL collide_sum: sum %h cout %b want sum 02 cout 0", sum, cout);
        end
        extra = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL collide_single: got %0d extra busy/done cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int bc; bit seen;
        launch(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(bc, seen);
        checks++;
        if (!seen || sum !== 8'h10) begin
            errors++;
            $display("FAIL b2b_first: seen %b sum %h want seen 1 sum 10", seen, sum);
        end
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
            errors++;
            $display("FAIL b2b_accept: busy %b done %b sum %h want busy 1 done 0 sum 00", busy, done, sum);
        end
        wait_done(bc, seen);
        checks++;
        if (!seen || bc != 4) begin
            errors++;
            $display("FAIL b2b_latency: seen %b busy cycles %0d want seen 1 cycles 4", seen, bc);
        end
        checks++;
        if (sum !== 8'h46 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sum: sum %h cout %b want sum 46 cout 0", sum, cout);
        end
        sub = 1'b0; cin = 1'b0;
        step();
    endtask

    task automatic test_reset_midop();
        int bc; bit seen; int stray;
        launch(8'hF0, 8'h0F, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== 8'h00 || busy !== 1'b0 || cout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: sum %h busy %b cout %b done %b want 00 0 0 0", sum, busy, cout, done);
        end
        step();
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midop_no_done: got %0d busy/done cycles want 0", stray); end
        launch(8'h03, 8'h04, 1'b0, 1'b0);
        wait_done(bc, seen);
        checks++;
        if (!seen || sum !== 8'h07 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midop_next: seen %b sum %h cout %b want 1 07 0", seen, sum, cout);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ripple();
        test_sub();
        test_collision();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
